// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   state_e : controller state (CLEAR while the SRAM is being zeroed, RUN afterwards)
//   PORT_IF : index of the instruction-fetch port in grant/request vectors
//   PORT_D  : index of the data port in grant/request vectors
package mem_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int PORT_IF = 0;
    localparam int PORT_D  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
//   clk     : clock
//   rst     : synchronous active-high reset (pointer favours the data port)
//   en_i    : grants allowed this cycle
//   req_i   : requests, indexed by PORT_IF / PORT_D
//   gnt_o   : one-hot (or zero) grant, combinational from req_i and the pointer
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // 1: data port wins the next tie, 0: fetch port wins it
    logic favor_d_q;
    logic favor_d_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[PORT_IF] && req_i[PORT_D]) begin
                gnt_o[PORT_D]  = favor_d_q;
                gnt_o[PORT_IF] = ~favor_d_q;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // The port just served loses the next tie; without a grant the pointer holds.
    always_comb begin
        favor_d_d = favor_d_q;
        if (gnt_o[PORT_D]) begin
            favor_d_d = 1'b0;
        end else if (gnt_o[PORT_IF]) begin
            favor_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            favor_d_q <= 1'b1;
        end else begin
            favor_d_q <= favor_d_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch + data) arbiter in front of a single-port SRAM
// with registered 1-cycle read data. After reset the SRAM is zeroed one word
// per cycle; requests are only granted once the clear has finished.
//   clk, rst                       : clock, synchronous active-high reset
//   i_if_req/i_if_addr             : fetch read request and address
//   o_if_gnt/o_if_rvalid/o_if_rdata: fetch grant, read-data valid, read data
//   i_d_req/i_d_we/i_d_addr/i_d_wdata : data-port request
//   o_d_gnt/o_d_rvalid/o_d_rdata   : data grant, read-data valid, read data
//   o_mem_addr/o_mem_wdata/o_mem_we: SRAM command
//   i_mem_rdata                    : SRAM registered read data
//   o_init_done                    : clear complete, grants permitted
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | zeroing SRAM, address = clear counter, no grants
// RUN   | arbitrating fetch/data requests onto the SRAM
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_DEPTH = 4096,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [WORD_WIDTH-1:0] o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [WORD_WIDTH-1:0] i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [WORD_WIDTH-1:0] o_d_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [WORD_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [WORD_WIDTH-1:0] i_mem_rdata,
    output logic                  o_init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  pend_port_q, pend_port_d;   // 1 = data port

    logic [1:0] req;
    logic [1:0] gnt;
    logic       run;

    assign run         = (state_q == RUN);
    assign req[PORT_IF] = i_if_req;
    assign req[PORT_D]  = i_d_req;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .en_i  (run),
        .req_i (req),
        .gnt_o (gnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_port_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_port_q <= pend_port_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase

        // Tag the read granted this cycle so its data is routed back next cycle.
        pend_vld_d  = gnt[PORT_IF] | (gnt[PORT_D] & ~i_d_we);
        pend_port_d = gnt[PORT_D];
    end

    // Output logic
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (state_q == CLEAR) begin
            o_mem_we   = 1'b1;
            o_mem_addr = clr_cnt_q;
        end else if (gnt[PORT_D]) begin
            o_mem_we    = i_d_we;
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
        end else if (gnt[PORT_IF]) begin
            o_mem_addr = i_if_addr;
        end
    end

    assign o_if_gnt    = gnt[PORT_IF];
    assign o_d_gnt     = gnt[PORT_D];
    assign o_if_rvalid = pend_vld_q & ~pend_port_q;
    assign o_d_rvalid  = pend_vld_q &  pend_port_q;
    assign o_if_rdata  = i_mem_rdata;
    assign o_d_rdata   = i_mem_rdata;
    assign o_init_done = run;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW    = 12;
    localparam int DEPTH = 16;
    localparam int WW    = 16;

    logic          clk;
    logic          rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [WW-1:0] o_if_rdata;
    logic          i_d_req;
    logic          i_d_we;
    logic [AW-1:0] i_d_addr;
    logic [WW-1:0] i_d_wdata;
    logic          o_d_gnt;
    logic          o_d_rvalid;
    logic [WW-1:0] o_d_rdata;
    logic [AW-1:0] o_mem_addr;
    logic [WW-1:0] o_mem_wdata;
    logic          o_mem_we;
    logic [WW-1:0] i_mem_rdata;
    logic          o_init_done;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .WORD_DEPTH (DEPTH),
        .WORD_WIDTH (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .i_mem_rdata (i_mem_rdata),
        .o_init_done (o_init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, 1-cycle latency, preloaded with non-zero junk
    logic [WW-1:0] sram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'hA5A5 ^ 16'(i);
        i_mem_rdata = '0;
    end
    always @(posedge clk) begin
        i_mem_rdata <= sram[o_mem_addr];
        if (o_mem_we) sram[o_mem_addr] <= o_mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ifr, input logic [AW-1:0] ifa, input logic dr,
                          input logic dwe, input logic [AW-1:0] da, input logic [WW-1:0] dwd);
        i_if_req  = ifr;
        i_if_addr = ifa;
        i_d_req   = dr;
        i_d_we    = dwe;
        i_d_addr  = da;
        i_d_wdata = dwd;
    endtask

    typedef struct packed {
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [WW-1:0] d_wdata;
        logic          e_if_gnt;
        logic          e_d_gnt;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [WW-1:0] e_wdata;
        logic          e_if_rv;
        logic          e_d_rv;
        logic [WW-1:0] e_rdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // inputs: if_req if_addr d_req d_we d_addr d_wdata | expected: if_gnt d_gnt we addr wdata if_rv d_rv rdata
        vecs[0]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h005, 16'h1234, 1'b0, 1'b1, 1'b1, 12'h005, 16'h1234, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h001, 16'hABCD, 1'b0, 1'b1, 1'b1, 12'h001, 16'hABCD, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 12'h00A, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h00A, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[7]  = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 16'hABCD};
        vecs[8]  = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[9]  = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 16'hABCD};
        vecs[10] = '{1'b1, 12'h001, 1'b1, 1'b0, 12'h005, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 16'hABCD};

        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Reset held: outputs idle, CLEAR pinned at address 0
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check("rst_outputs", {o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_init_done}, 5'b0);
                check("rst_clear_addr0", {o_mem_we, o_mem_addr}, {1'b1, 12'h000});
            end
        end
        next_cycle();
        rst = 1'b0;

        // Clear sequence: DEPTH writes of zero, then init_done in cycle DEPTH+1
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            check("clear_cmd", {o_mem_we, o_mem_addr, o_mem_wdata}, {1'b1, 12'(a), 16'h0000});
            check("clear_idle", {o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_init_done}, 5'b0);
            next_cycle();
        end
        @(negedge clk);
        check("init_done", {31'b0, o_init_done}, 32'd1);
        next_cycle();

        // Directed vectors
        for (int v = 0; v < 12; v++) begin
            set_in(vecs[v].if_req, vecs[v].if_addr, vecs[v].d_req, vecs[v].d_we,
                   vecs[v].d_addr, vecs[v].d_wdata);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", v), {o_if_gnt, o_d_gnt}, {vecs[v].e_if_gnt, vecs[v].e_d_gnt});
            check($sformatf("vec%0d_mem", v), {o_mem_we, o_mem_addr}, {vecs[v].e_we, vecs[v].e_addr});
            if (!vecs[v].e_if_gnt)
                check($sformatf("vec%0d_wdata", v), {48'b0, o_mem_wdata}, {48'b0, vecs[v].e_wdata});
            check($sformatf("vec%0d_rvalid", v), {o_if_rvalid, o_d_rvalid}, {vecs[v].e_if_rv, vecs[v].e_d_rv});
            if (vecs[v].e_if_rv)
                check($sformatf("vec%0d_if_rdata", v), {48'b0, o_if_rdata}, {48'b0, vecs[v].e_rdata});
            if (vecs[v].e_d_rv)
                check($sformatf("vec%0d_d_rdata", v), {48'b0, o_d_rdata}, {48'b0, vecs[v].e_rdata});
            next_cycle();
        end

        // Reset in the same cycle a fetch read is granted
        set_in(1'b1, 12'h005, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("rstgnt_if_gnt", {o_if_gnt, o_mem_we, o_mem_addr}, {1'b1, 1'b0, 12'h005});
        next_cycle();
        rst = 1'b0;
        // Both ports request during CLEAR and hold
        set_in(1'b1, 12'h00A, 1'b1, 1'b0, 12'h005, 16'h0000);
        @(negedge clk);
        check("rstgnt_no_rvalid", {o_if_rvalid, o_d_rvalid}, 2'b00);
        check("rstgnt_clear_addr0", {o_mem_we, o_mem_addr, o_init_done}, {1'b1, 12'h000, 1'b0});
        for (int a = 1; a < DEPTH; a++) begin
            next_cycle();
            @(negedge clk);
            check("hold_no_gnt", {o_if_gnt, o_d_gnt, o_mem_addr}, {2'b00, 12'(a)});
        end
        next_cycle();
        @(negedge clk);
        // First RUN cycle: tie goes to the data port after reset
        check("first_run_gnt", {o_init_done, o_if_gnt, o_d_gnt, o_mem_we, o_mem_addr},
              {1'b1, 1'b0, 1'b1, 1'b0, 12'h005});
        next_cycle();
        i_d_req = 1'b0;
        @(negedge clk);
        check("held_if_gnt", {o_if_gnt, o_d_gnt, o_mem_addr}, {2'b10, 12'h00A});
        check("d_rv_after_clear", {o_if_rvalid, o_d_rvalid, o_d_rdata}, {2'b01, 16'h0000});
        next_cycle();
        i_if_req = 1'b0;
        @(negedge clk);
        check("if_rv_cleared_addr", {o_if_rvalid, o_d_rvalid, o_if_rdata}, {2'b10, 16'h0000});
        check("idle_mem", {o_if_gnt, o_d_gnt, o_mem_we, o_mem_addr, o_mem_wdata}, 31'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SRAM address width.
REQ-002 Parameter WORD_DEPTH, default 4096, SRAM words to clear at init.
REQ-003 Parameter WORD_WIDTH, default 16, data word width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 i_if_req  input  1  instruction-fetch read request; held until granted.
REQ-007 i_if_addr  input  ADDR_WIDTH  fetch address; stable while i_if_req=1.
REQ-008 o_if_gnt  output  1  fetch request accepted this cycle.
REQ-009 o_if_rvalid  output  1  o_if_rdata valid this cycle.
REQ-010 o_if_rdata  output  WORD_WIDTH  fetch read data.
REQ-011 i_d_req  input  1  data-port request; held until granted.
REQ-012 i_d_we  input  1  data-port request is a write (1) or read (0).
REQ-013 i_d_addr  input  ADDR_WIDTH  data-port address.
REQ-014 i_d_wdata  input  WORD_WIDTH  data-port write data.
REQ-015 o_d_gnt  output  1  data request accepted this cycle.
REQ-016 o_d_rvalid  output  1  o_d_rdata valid this cycle; never asserted for writes.
REQ-017 o_d_rdata  output  WORD_WIDTH  data-port read data.
REQ-018 o_mem_addr / o_mem_wdata / o_mem_we  output  ADDR_WIDTH / WORD_WIDTH / 1  drive the SRAM address, write data, write enable (SRAM reads when we=0, data registered, 1-cycle latency).
REQ-019 i_mem_rdata  input  WORD_WIDTH  SRAM registered read data.
REQ-020 o_init_done  output  1  SRAM clear complete; grants permitted.

Function
REQ-021 FSM states CLEAR and RUN; CLEAR entered on reset.
REQ-022 CLEAR: one word per cycle, o_mem_we=1, o_mem_wdata=0, o_mem_addr=clear counter from 0 upward; no grants, no rvalid.
REQ-023 CLEAR->RUN on the cycle after address WORD_DEPTH-1 is written (WORD_DEPTH cycles in CLEAR); o_init_done=1 exactly in RUN.
REQ-024 RUN: at most one grant per cycle; gnt is combinational from req and registered state, single-cycle pulse.
REQ-025 Single requester: granted the same cycle it requests.
REQ-026 Both requesting: round-robin; port not granted last wins; after reset the data port wins the first tie.
REQ-027 Grant drives SRAM that cycle: fetch -> addr=i_if_addr, we=0; data -> addr=i_d_addr, we=i_d_we, wdata=i_d_wdata.
REQ-028 Read granted in cycle N -> matching rvalid=1 in cycle N+1, rdata=i_mem_rdata; other port's rvalid stays 0.
REQ-029 Back-to-back grants every cycle allowed; read-after-write to same address in consecutive cycles returns the written value.
REQ-030 No grant in RUN: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
REQ-031 o_if_rdata/o_d_rdata are don't-care when the respective rvalid=0.

Reset
REQ-032 rst=1 at any edge: state=CLEAR, clear counter=0, RR pointer=favor data, pending-read tag cleared; outputs next cycle: gnts=0, rvalids=0, o_init_done=0.
REQ-033 Reset mid-read: the read granted in the reset cycle produces no rvalid.
REQ-034 rst held: CLEAR restarts from address 0 every cycle.

Structure
REQ-035 Package mem_arb_pkg holds the state enum (CLEAR, RUN) and port index constants (PORT_IF=0, PORT_D=1).
REQ-036 One sub-module rr_arb2: 2-input round-robin arbiter with registered last-grant pointer.
REQ-037 Registered state limited to FSM state, clear counter, RR pointer, pending-read tag (valid + port).

Verification
REQ-038 Reset, WORD_DEPTH=16 -> 16 writes of 0 to addr 0..15, o_init_done=1 in 17th cycle after rst deassert, no grants before.
REQ-039 After init, data write 0x1234 @0x005, next cycle data read @0x005 -> o_d_gnt each cycle, o_d_rvalid one cycle after read with 0x1234.
REQ-040 Both ports request reads continuously for 6 cycles -> grants alternate D,IF,D,IF,D,IF; each rvalid on the owning port one cycle after its grant.
REQ-041 Fetch read of a cleared address (0x00A) -> o_if_rvalid=1, o_if_rdata=0x0000, o_d_rvalid=0.
REQ-042 rst asserted the cycle a fetch read is granted -> no o_if_rvalid next cycle; CLEAR restarts at addr 0.
REQ-043 Requests asserted during CLEAR -> held, no gnt until o_init_done=1, then granted first RUN cycle.
